// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// The tag/data arrays live in registers, and hits are answered combinationally.
// A three-state FSM (IDLE/FILL/WRITE) drives a single-transaction, word-wide
// memory port.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   dcache_prefetch/pre_addr prefetch hint (dropped unless taken in IDLE)
//   dcache_read/read_addr    demand read, held by the LSU until read_done
//   dcache_read_done/data    combinational hit response (data is 0 when not done)
//   dcache_write*            committed store (word address, data, byte mask)
//   dcache_write_done        one-cycle pulse after the store reaches memory
//   mem_req/we/addr/wdata/wmask  registered memory request
//   mem_ready/mem_rdata      beat completion and read data
module data_cache #(
  parameter int unsigned LINE_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_prefetch,
  input  logic [31:0] dcache_pre_addr,
  input  logic        dcache_read,
  input  logic [31:0] dcache_read_addr,
  output logic        dcache_read_done,
  output logic [31:0] dcache_read_data,
  input  logic        dcache_write,
  input  logic [31:0] dcache_write_addr,
  input  logic [31:0] dcache_write_data,
  input  logic [3:0]  dcache_write_mask,
  output logic        dcache_write_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LINES = 1 << LINE_BITS;
  localparam int unsigned TAG_W = 32 - LINE_BITS - 4;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];

  logic [TAG_W-1:0]     fill_tag_q;
  logic [LINE_BITS-1:0] fill_idx_q;
  logic [1:0]           beat_q;

  // Address fields
  logic [TAG_W-1:0]     rd_tag, pre_tag, wr_tag, fa_tag;
  logic [LINE_BITS-1:0] rd_idx, pre_idx, wr_idx, fa_idx;
  logic [1:0]           rd_word, wr_word;
  logic                 rd_hit, pre_hit, wr_hit;
  logic                 write_take;
  logic [31:0]          fill_addr_d;
  logic [31:0]          wr_old, wr_merged;

  assign rd_tag  = dcache_read_addr[31:LINE_BITS+4];
  assign rd_idx  = dcache_read_addr[LINE_BITS+3:4];
  assign rd_word = dcache_read_addr[3:2];
  assign pre_tag = dcache_pre_addr[31:LINE_BITS+4];
  assign pre_idx = dcache_pre_addr[LINE_BITS+3:4];
  // The latched store address is held on mem_addr throughout WRITE.
  assign wr_tag  = mem_addr[31:LINE_BITS+4];
  assign wr_idx  = mem_addr[LINE_BITS+3:4];
  assign wr_word = mem_addr[3:2];
  assign fa_tag  = fill_addr_d[31:LINE_BITS+4];
  assign fa_idx  = fill_addr_d[LINE_BITS+3:4];

  assign rd_hit  = valid_q[rd_idx]  && (tag_q[rd_idx]  == rd_tag);
  assign pre_hit = valid_q[pre_idx] && (tag_q[pre_idx] == pre_tag);
  assign wr_hit  = valid_q[wr_idx]  && (tag_q[wr_idx]  == wr_tag);

  // The committer still holds dcache_write in the cycle it sees
  // write_done. Ignore it then so the store is not issued a second time.
  assign write_take = dcache_write && !dcache_write_done;

  assign wr_old    = data_q[wr_idx][wr_word];
  assign wr_merged = {mem_wmask[3] ? mem_wdata[31:24] : wr_old[31:24],
                      mem_wmask[2] ? mem_wdata[23:16] : wr_old[23:16],
                      mem_wmask[1] ? mem_wdata[15:8]  : wr_old[15:8],
                      mem_wmask[0] ? mem_wdata[7:0]   : wr_old[7:0]};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dcache_read_addr[1:0], dcache_pre_addr[3:0],
                              dcache_write_addr[1:0], fill_addr_d[3:0]};

  // State register and control/datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      valid_q           <= '0;
      fill_tag_q        <= '0;
      fill_idx_q        <= '0;
      beat_q            <= '0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem_wmask         <= '0;
      dcache_write_done <= 1'b0;
    end else begin
      state_q           <= state_d;
      dcache_write_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == FILL) begin
            fill_tag_q      <= fa_tag;
            fill_idx_q      <= fa_idx;
            beat_q          <= '0;
            valid_q[fa_idx] <= 1'b0;
            mem_req         <= 1'b1;
            mem_we          <= 1'b0;
            mem_addr        <= {fa_tag, fa_idx, 4'b0000};
          end else if (state_d == WRITE) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {dcache_write_addr[31:2], 2'b00};
            mem_wdata <= dcache_write_data;
            mem_wmask <= dcache_write_mask;
          end
        end
        FILL: begin
          if (mem_ready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              valid_q[fill_idx_q] <= 1'b1;
              mem_req             <= 1'b0;
            end else begin
              mem_addr <= {fill_tag_q, fill_idx_q, beat_q + 2'd1, 2'b00};
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            dcache_write_done <= 1'b1;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && state_d == FILL)
      tag_q[fa_idx] <= fa_tag;
    if (state_q == FILL && mem_ready)
      data_q[fill_idx_q][beat_q] <= mem_rdata;
    if (state_q == WRITE && mem_ready && wr_hit)
      data_q[wr_idx][wr_word] <= wr_merged;
  end

  // Next-state logic, with fill-address selection in IDLE
  always_comb begin
    state_d     = state_q;
    fill_addr_d = dcache_read_addr;
    case (state_q)
      IDLE: begin
        if (write_take) begin
          state_d = WRITE;
        end else if (dcache_read && !rd_hit) begin
          state_d = FILL;
        end else if (dcache_prefetch && !pre_hit) begin
          state_d     = FILL;
          fill_addr_d = dcache_pre_addr;
        end
      end
      FILL:    if (mem_ready && beat_q == 2'd3) state_d = IDLE;
      WRITE:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read response, served from the arrays in every state
  always_comb begin
    dcache_read_done = dcache_read && rd_hit;
    dcache_read_data = '0;
    if (dcache_read_done)
      dcache_read_data = data_q[rd_idx][rd_word];
  end

endmodule

// File: tb/tb_data_cache.sv
`timescale 1ns/1ps
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dcache_prefetch = 1'b0;
  logic [31:0] dcache_pre_addr = '0;
  logic        dcache_read = 1'b0;
  logic [31:0] dcache_read_addr = '0;
  logic        dcache_read_done;
  logic [31:0] dcache_read_data;
  logic        dcache_write = 1'b0;
  logic [31:0] dcache_write_addr = '0;
  logic [31:0] dcache_write_data = '0;
  logic [3:0]  dcache_write_mask = '0;
  logic        dcache_write_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  data_cache #(.LINE_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .dcache_prefetch(dcache_prefetch), .dcache_pre_addr(dcache_pre_addr),
    .dcache_read(dcache_read), .dcache_read_addr(dcache_read_addr),
    .dcache_read_done(dcache_read_done), .dcache_read_data(dcache_read_data),
    .dcache_write(dcache_write), .dcache_write_addr(dcache_write_addr),
    .dcache_write_data(dcache_write_data), .dcache_write_mask(dcache_write_mask),
    .dcache_write_done(dcache_write_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference model: which lines are resident, and what memory should hold
  logic        mdl_valid [16];
  logic [23:0] mdl_tag   [16];

  function automatic logic mdl_hit(input logic [31:0] a);
    return mdl_valid[a[7:4]] && (mdl_tag[a[7:4]] == a[31:8]);
  endfunction

  task automatic mdl_fill(input logic [31:0] a);
    mdl_valid[a[7:4]] = 1'b1;
    mdl_tag[a[7:4]]   = a[31:8];
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
  endtask

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  // Power-on memory image: line 0x100 holds 0xA0..0xA3, other lines are distinct
  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [27:0] l;
    l = a[31:4] ^ 28'h0000010;
    return {l[23:0], 8'h00} | (32'h0000_00A0 + {30'b0, a[3:2]});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    if (m[0]) r[7:0]   = d[7:0];
    if (m[1]) r[15:8]  = d[15:8];
    if (m[2]) r[23:16] = d[23:16];
    if (m[3]) r[31:24] = d[31:24];
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] phys_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return phys_mem.exists(k) ? phys_mem[k] : init_word(k);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  txn_t txn_q[$];
  txn_t last_txn;
  bit   rdy_always = 1'b1;

  // Memory side: a transaction completes at the edge that ends a cycle with req && ready
  always @(negedge clk) begin
    if (rst && mem_req && mem_ready) begin
      last_txn.we    = mem_we;
      last_txn.addr  = mem_addr;
      last_txn.wdata = mem_wdata;
      last_txn.wmask = mem_wmask;
      txn_q.push_back(last_txn);
      if (mem_we)
        phys_mem[{mem_addr[31:2], 2'b00}] = merge(phys_word(mem_addr), mem_wdata, mem_wmask);
    end
  end

  always @(posedge clk) begin
    #1;
    mem_ready = mem_req && (rdy_always || ($urandom_range(0, 2) != 0));
    mem_rdata = mem_ready ? phys_word(mem_addr) : 32'hDEAD_BEEF;
  end

  // Scoreboard monitor
  logic [31:0] exp_rd_q[$];
  txn_t        exp_wr_q[$];
  logic        prev_pending = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wmask;

  always @(negedge clk) begin
    logic [31:0] e;
    txn_t        w;
    if (rst && dcache_read_done) begin
      if (exp_rd_q.size() == 0) fail_now("read_done", "unexpected read completion");
      else begin
        e = exp_rd_q.pop_front();
        check("read_data", dcache_read_data, e);
      end
    end
    if (rst && dcache_write_done) begin
      if (exp_wr_q.size() == 0) fail_now("write_done", "unexpected write completion");
      else begin
        w = exp_wr_q.pop_front();
        check_bit("store_we", last_txn.we, 1'b1);
        check("store_addr", last_txn.addr, w.addr);
        check("store_wdata", last_txn.wdata, w.wdata);
        check("store_wmask", {28'b0, last_txn.wmask}, {28'b0, w.wmask});
      end
    end
    if (rst && prev_pending) begin
      check_bit("req_held", mem_req, 1'b1);
      check("req_addr_stable", mem_addr, prev_addr);
      check_bit("req_we_stable", mem_we, prev_we);
      if (prev_we) begin
        check("req_wdata_stable", mem_wdata, prev_wdata);
        check("req_wmask_stable", {28'b0, mem_wmask}, {28'b0, prev_wmask});
      end
    end
    prev_pending = rst && mem_req && !mem_ready;
    prev_we      = mem_we;
    prev_addr    = mem_addr;
    prev_wdata   = mem_wdata;
    prev_wmask   = mem_wmask;
  end

  // Drivers: each starts 1ns after a rising edge and returns at the same phase
  task automatic do_read(input logic [31:0] a, input int exp_lat);
    int lat;
    bit done;
    logic hit;
    hit = mdl_hit(a);
    exp_rd_q.push_back(ref_word(a));
    dcache_read_addr = a;
    dcache_read      = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (dcache_read_done) done = 1'b1;
      else lat++;
    end
    if (!done) begin
      fail_now("read_timeout", $sformatf("read 0x%08h never completed", a));
      void'(exp_rd_q.pop_back());
    end else if (hit) check("read_hit_latency", lat, 0);
    else if (exp_lat >= 0) check("read_miss_latency", lat, exp_lat);
    else check_bit("read_miss_min_latency", lat >= 5, 1'b1);
    mdl_fill(a);
    @(posedge clk);
    #1;
    dcache_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input int exp_lat);
    txn_t t;
    int lat;
    bit done;
    t.we = 1'b1;
    t.addr = {a[31:2], 2'b00};
    t.wdata = d;
    t.wmask = m;
    exp_wr_q.push_back(t);
    ref_mem[{a[31:2], 2'b00}] = merge(ref_word(a), d, m);
    dcache_write_addr = a;
    dcache_write_data = d;
    dcache_write_mask = m;
    dcache_write      = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (dcache_write_done) done = 1'b1;
      else lat++;
    end
    if (!done) begin
      fail_now("write_timeout", $sformatf("store 0x%08h never completed", a));
      void'(exp_wr_q.pop_back());
    end else if (exp_lat >= 0) check("write_latency", lat, exp_lat);
    else check_bit("write_min_latency", lat >= 2, 1'b1);
    @(posedge clk);
    #1;
    dcache_write = 1'b0;
  endtask

  task automatic do_prefetch(input logic [31:0] a);
    logic hit;
    int n;
    hit = mdl_hit(a);
    dcache_pre_addr = a;
    dcache_prefetch = 1'b1;
    @(posedge clk);
    #1;
    dcache_prefetch = 1'b0;
    @(negedge clk);
    check_bit("prefetch_req", mem_req, !hit);
    if (!hit) begin
      mdl_fill(a);
      n = 0;
      while (mem_req && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("prefetch_timeout", "fill never finished");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_fill_txns(input string name, input int base, input logic [31:0] line);
    for (int k = 0; k < 4; k++) begin
      if (txn_q.size() > base + k) begin
        check(name, txn_q[base+k].addr, line + 32'(4 * k));
        check_bit(name, txn_q[base+k].we, 1'b0);
      end else begin
        fail_now(name, $sformatf("beat %0d missing", k));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    int unsigned op;
    mdl_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("reset_mem_req", mem_req, 1'b0);
    check_bit("reset_mem_we", mem_we, 1'b0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    check_bit("reset_write_done", dcache_write_done, 1'b0);
    check_bit("reset_read_done", dcache_read_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, then hit in the following cycle
    txn_q.delete();
    do_read(32'h100, 5);
    check("cold_fill_count", txn_q.size(), 4);
    check_fill_txns("cold_fill_addr", 0, 32'h100);
    do_read(32'h108, -1);

    // Store to a resident line; read it in the write_done cycle
    txn_q.delete();
    fork
      do_write(32'h104, 32'h0000_5500, 4'b0010, 2);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        do_read(32'h104, -1);
      end
    join
    check("store_txn_count", txn_q.size(), 1);

    // Store miss must not disturb line 0
    do_write(32'h900, $urandom, 4'hF, 2);
    txn_q.delete();
    do_read(32'h100, -1);
    check("no_alloc_txn_count", txn_q.size(), 0);

    // Conflict on index 0
    do_read(32'h200, 5);
    do_read(32'h100, 5);

    // Prefetch fill, then hit without a request
    txn_q.delete();
    do_prefetch(32'h140);
    check("prefetch_txn_count", txn_q.size(), 4);
    check_fill_txns("prefetch_fill_addr", 0, 32'h140);
    txn_q.delete();
    do_read(32'h14C, -1);
    check("prefetch_hit_txn_count", txn_q.size(), 0);

    // Prefetch during a fill is dropped
    txn_q.delete();
    fork
      do_read(32'h300, 5);
      begin
        repeat (2) @(posedge clk);
        #1;
        dcache_pre_addr = 32'h180;
        dcache_prefetch = 1'b1;
        @(posedge clk);
        #1;
        dcache_prefetch = 1'b0;
      end
    join
    check("busy_prefetch_txn_count", txn_q.size(), 4);
    check_fill_txns("busy_prefetch_fill_addr", 0, 32'h300);
    do_read(32'h180, 5);

    // Write, missing read and prefetch together
    txn_q.delete();
    fork
      do_write(32'h124, $urandom, 4'hF, 2);
      do_read(32'h380, 7);
      begin
        dcache_pre_addr = 32'h1C0;
        dcache_prefetch = 1'b1;
        @(posedge clk);
        #1;
        dcache_prefetch = 1'b0;
      end
    join
    check("priority_txn_count", txn_q.size(), 5);
    if (txn_q.size() > 0) begin
      check_bit("priority_first_we", txn_q[0].we, 1'b1);
      check("priority_first_addr", txn_q[0].addr, 32'h124);
    end
    check_fill_txns("priority_fill_addr", 1, 32'h380);
    do_read(32'h1C0, 5);
    do_read(32'h124, 5);

    // Reset during beat 2 of a fill
    dcache_read_addr = 32'h400;
    dcache_read = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h408) break;
      n++;
    end
    if (n >= 50) fail_now("reset_fill_reach", "beat 2 never presented");
    #1;
    rst = 1'b0;
    #1;
    check_bit("midfill_reset_req", mem_req, 1'b0);
    check("midfill_reset_addr", mem_addr, 32'h0);
    check_bit("midfill_reset_read_done", dcache_read_done, 1'b0);
    dcache_read = 1'b0;
    mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    txn_q.delete();
    do_read(32'h400, 5);
    check("refill_txn_count", txn_q.size(), 4);
    check_fill_txns("refill_addr", 0, 32'h400);

    // Random traffic with a stalling memory
    rdy_always = 1'b0;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      op = $urandom_range(0, 9);
      if (op < 6) do_read(a, -1);
      else if (op < 8) do_write(a, $urandom, 4'($urandom_range(0, 15)), -1);
      else do_prefetch(a);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_reads_drained", exp_rd_q.size(), 0);
    check("scoreboard_writes_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
